// File: rtl/serial_word_tx_pkg.sv
// Shared types and sizing for the serial word transmitter.
// Default word length matches the downstream 16-bit SIPO register.
package serial_word_tx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int WIDTH_DEF = 16;
  localparam int BITCNT_W  = $clog2(WIDTH_DEF);

  function automatic int cnt_bits(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_word_tx_chk.sv
// Loopback checker: compares downstream Q with the word just sent.
// Built only when SERIAL_WORD_TX_CHECK_EN is defined.
module serial_word_tx_chk
  import serial_word_tx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             accept,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             finish,
  input  logic             word_done,
  input  logic [WIDTH-1:0] q_in,
  output logic             chk_err
);

  // Two slots: a back-to-back accept overwrites pend while
  // ref_w still holds the word whose word_done is pending.
  logic [WIDTH-1:0] pend;
  logic [WIDTH-1:0] ref_w;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      pend    <= '0;
      ref_w   <= '0;
      chk_err <= 1'b0;
    end else begin
      if (accept)
        pend <= ld_data;
      if (finish)
        ref_w <= pend;
      if (word_done && (q_in != ref_w))
        chk_err <= 1'b1;
    end
  end

endmodule

// File: rtl/serial_word_tx.sv
// LSB-first parallel-to-serial transmitter feeding a SIPO register.
// Optional loopback check: define SERIAL_WORD_TX_CHECK_EN.
module serial_word_tx
  import serial_word_tx_pkg::*;
#(
  parameter int   WIDTH    = WIDTH_DEF,
  parameter logic IDLE_BIT = 1'b0,
  parameter int   CNT_W    = 8
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             ld_valid,
  output logic             ld_ready,
  output logic             sdo,
  output logic             busy,
  output logic             word_done,
  output logic [CNT_W-1:0] words_sent,
  input  logic [WIDTH-1:0] q_in,
  output logic             chk_err
);

  localparam int CW = (WIDTH == WIDTH_DEF) ? BITCNT_W
                                           : cnt_bits(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [WIDTH-1:0] sreg, sreg_nx;
  logic             sdo_nx;
  logic             last;
  logic             accept;

  assign last     = (state == SHIFT) && (cnt == LAST);
  assign ld_ready = (state == IDLE) || last;
  assign accept   = ld_valid && ld_ready;
  assign busy     = (state == SHIFT);

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state      <= IDLE;
      cnt        <= '0;
      sreg       <= '0;
      sdo        <= IDLE_BIT;
      word_done  <= 1'b0;
      words_sent <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      sreg      <= sreg_nx;
      sdo       <= sdo_nx;
      word_done <= last;
      if (last)
        words_sent <= words_sent + 1'b1;
    end
  end

  // sdo is registered: it always carries the bit the next
  // downstream edge will sample.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sreg_nx  = sreg;
    sdo_nx   = sdo;
    unique case (1'b1)
      accept: begin
        state_nx = SHIFT;
        cnt_nx   = '0;
        sreg_nx  = ld_data;
        sdo_nx   = ld_data[0];
      end
      last && !accept: begin
        state_nx = IDLE;
        sdo_nx   = IDLE_BIT;
      end
      (state == SHIFT) && !last: begin
        cnt_nx  = cnt + 1'b1;
        sreg_nx = sreg >> 1;
        sdo_nx  = sreg[1];
      end
      default: ;
    endcase
  end

`ifdef SERIAL_WORD_TX_CHECK_EN
  serial_word_tx_chk #(
    .WIDTH(WIDTH)
  ) u_chk (
    .CLK      (CLK),
    .CLR      (CLR),
    .accept   (accept),
    .ld_data  (ld_data),
    .finish   (last),
    .word_done(word_done),
    .q_in     (q_in),
    .chk_err  (chk_err)
  );
`else
  logic unused_q_in;
  assign unused_q_in = ^q_in;
  assign chk_err     = 1'b0;
`endif

endmodule

// File: doc/serial_word_tx.md
Name: serial_word_tx

Overview:
- Parallel-to-serial transmitter that sits directly upstream of the 16-bit serial-in/parallel-out shift register and drives its D input.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it LSB-first, one bit per CLK. After WIDTH edges the full word sits in the downstream Q[WIDTH-1:0] in natural bit order.
- Pulses word_done on the one cycle in which downstream Q holds the complete word, so a consumer can latch it.

Parameters:
- WIDTH, 16: word length in bits; must equal the downstream shift register length; legal range 2..64.
- IDLE_BIT, 0: level driven on sdo when no word is in flight.
- CNT_W, 8: width of the words_sent counter.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- CLR  in  1  reset; asynchronous, active-high.
- ld_data  in  WIDTH  word to transmit.
- ld_valid  in  1  ld_data is valid.
- ld_ready  out  1  block accepts ld_data this cycle.
- sdo  out  1  serial bit; connects to downstream D.
- busy  out  1  a word is being shifted out.
- word_done  out  1  one-cycle pulse; downstream Q holds the completed word.
- words_sent  out  CNT_W  count of completed words; wraps modulo 2^CNT_W.
- q_in  in  WIDTH  downstream Q; used only when the optional feature is compiled in.
- chk_err  out  1  sticky mismatch flag; optional feature only.

Behaviour:
- Reset (CLR high, asynchronous):
  - state=IDLE, bit counter=0, shift register=0, sdo=IDLE_BIT.
  - busy=0, word_done=0, words_sent=0, chk_err=0.
  - A CLR in mid-word aborts the word. The word is not counted and word_done does not fire. The downstream register is cleared by the same CLR.
- States:
  - IDLE -> SHIFT when ld_valid && ld_ready at edge E0.
  - SHIFT stays in SHIFT while cnt < WIDTH-1.
  - At cnt == WIDTH-1, SHIFT goes to SHIFT again if a new word is accepted (back-to-back), otherwise to IDLE.
- Handshake: ld_ready = (state==IDLE) || (state==SHIFT && cnt==WIDTH-1).
  - Registered-state decode only; no combinational path from ld_valid.
  - ld_valid while ld_ready=0 is ignored; data is not captured and the source must hold it.
- Data path:
  - On accept at E0: the internal register loads ld_data and cnt=0.
  - sdo = reg[0], registered: bit i is driven from E_i to E_(i+1), i = 0..WIDTH-1.
  - Each subsequent edge shifts the register right and increments cnt.
- Timing:
  - Downstream samples bit i at E_(i+1), so Q equals the word from E_WIDTH to E_(WIDTH+1).
  - word_done is high exactly in that cycle. words_sent increments at E_WIDTH.
  - busy is high from E0 to E_WIDTH.
- Back-to-back: a word accepted at E_WIDTH has its bit 0 on sdo from E_WIDTH. The stream is gapless, busy stays high, and word_done still pulses for the previous word.
- Idle: with no accept at E_WIDTH, sdo returns to IDLE_BIT and busy=0.
- Counter wrap: words_sent at 2^CNT_W-1 wraps to 0 on the next completion.

Optional Feature:
- Macro: SERIAL_WORD_TX_CHECK_EN.
- Defined:
  - A WIDTH-bit copy of each accepted word is kept until its word_done.
  - In the word_done cycle, q_in is compared against that copy; on mismatch chk_err is set.
  - chk_err is sticky and cleared only by CLR.
- Undefined:
  - No copy register is built, q_in is ignored, and chk_err is tied to 0.
  - Ports are identical in both builds.

Decomposition:
- Shared package:
  - State encoding IDLE=1'b0, SHIFT=1'b1.
  - localparam BITCNT_W = $clog2(WIDTH).
  - Default WIDTH=16, shared with the shift register.
- One natural sub-module: serial_word_tx_chk, holding the copy register and comparator. It is instantiated only under SERIAL_WORD_TX_CHECK_EN.

Test Plan:
- Reset then load 16'hA5C3 at E0, with the shift register attached -> sdo sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1; Q=16'hA5C3 and word_done=1 only in cycle E16..E17; words_sent=1.
- Back-to-back: ld_valid held with 16'h0001 then 16'h8000 -> second accept at E16; word_done pulses at E16 and E32 with Q=16'h0001 then 16'h8000; busy never drops between the words.
- ld_valid asserted at E5 of a word with 16'hFFFF -> ignored until E16; no corruption of the in-flight word.
- CLR pulsed at E7 of 16'h1234 -> all outputs return to reset values immediately; no word_done; words_sent unchanged at 0.
- CNT_W=2, send 5 words -> words_sent sequence 1,2,3,0,1.
- With SERIAL_WORD_TX_CHECK_EN, force q_in bit 3 wrong during word_done -> chk_err=1 and stays 1 until CLR. Without the macro, the same stimulus leaves chk_err=0.
